dma_cfg_icb_regs: RTL

- Parametrised ICB slave register file for a multi-channel DMA engine.
- Provides CH_NUM independent channel register banks: SR, CTR, CR, SRC, DST and LEN.
- Adds byte-masked writes, a held response under backpressure, error responses, busy-write protection and self-clearing command pulses.
- Sits between the E203 peripheral ICB bus and the DMA channel datapaths.

---
 rtl/dma_cfg_icb_regs.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/dma_cfg_icb_regs.sv
// ICB slave register file holding CH_NUM DMA channel banks (SR/CTR/CR/SRC/DST/LEN).
// Define DMA_CFG_IRQ_EN to add the global IRQ_STAT/IRQ_EN bank and the irq output.
module dma_cfg_icb_regs #(
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned CH_STRIDE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 icb_cmd_valid,
  input  logic                 icb_cmd_read,
  input  logic [31:0]          icb_cmd_addr,
  input  logic [31:0]          icb_cmd_wdata,
  input  logic [3:0]           icb_cmd_wmask,
  output logic                 icb_cmd_ready,
  output logic                 icb_rsp_valid,
  input  logic                 icb_rsp_ready,
  output logic [31:0]          icb_rsp_rdata,
  output logic                 icb_rsp_err,
  input  logic [CH_NUM*8-1:0]  ch_sr,
  output logic [CH_NUM*8-1:0]  ch_ctr,
  output logic [CH_NUM*8-1:0]  ch_cr_pulse,
  output logic [CH_NUM*32-1:0] ch_src,
  output logic [CH_NUM*32-1:0] ch_dst,
  output logic [CH_NUM*32-1:0] ch_len
`ifdef DMA_CFG_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int unsigned OFF_W = $clog2(CH_STRIDE);

  logic        rsp_valid_q, rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic [7:0]  ctr_q   [CH_NUM];
  logic [7:0]  pulse_q [CH_NUM];
  logic [31:0] src_q   [CH_NUM];
  logic [31:0] dst_q   [CH_NUM];
  logic [31:0] len_q   [CH_NUM];

  logic        hs, aligned, ch_hit, chan_ok, glob_ok, wr_chan;
  logic        sel_sr, sel_ctr, sel_cr, sel_src, sel_dst, sel_len;
  logic [31:0] ch_idx, off;
  logic [7:0]  sr_sel, ctr_sel;
  logic [31:0] src_sel, dst_sel, len_sel;
  logic [CH_NUM-1:0] we_ch;

  logic unused_addr;
  if (ADDR_W < 32) begin : g_unused
    assign unused_addr = ^icb_cmd_addr[31:ADDR_W];
  end else begin : g_all_used
    assign unused_addr = 1'b0;
  end

  assign hs      = icb_cmd_valid & ~rsp_valid_q;
  assign ch_idx  = 32'(icb_cmd_addr[ADDR_W-1:OFF_W]);
  assign off     = 32'(icb_cmd_addr[OFF_W-1:0]);
  assign aligned = (icb_cmd_addr[1:0] == 2'b00);
  assign ch_hit  = (ch_idx < CH_NUM);
  assign sel_sr  = (off == 32'h00);
  assign sel_ctr = (off == 32'h04);
  assign sel_cr  = (off == 32'h08);
  assign sel_src = (off == 32'h0C);
  assign sel_dst = (off == 32'h10);
  assign sel_len = (off == 32'h14);
  assign chan_ok = aligned & ch_hit &
                   (sel_sr | sel_ctr | sel_cr | sel_src | sel_dst | sel_len);

`ifdef DMA_CFG_IRQ_EN
  logic              glob_hit, glob_stat, glob_en, glob_wr, irq_q;
  logic [CH_NUM-1:0] irq_stat_q, irq_stat_d, irq_en_q, irq_en_d;
  logic [CH_NUM-1:0] done_prev_q, done_now, irq_clr;

  assign glob_hit  = aligned & (ch_idx == CH_NUM);
  assign glob_stat = glob_hit & (off == 32'h00);
  assign glob_en   = glob_hit & (off == 32'h04);
  assign glob_ok   = glob_stat | glob_en;
  assign glob_wr   = hs & ~icb_cmd_read & glob_ok & icb_cmd_wmask[0];

  // A done edge in the same cycle as a W1C clear keeps the bit set.
  always_comb begin
    irq_clr  = '0;
    irq_en_d = irq_en_q;
    for (int unsigned c = 0; c < CH_NUM; c++) done_now[c] = ch_sr[c*8+1];
    if (glob_wr) begin
      if (glob_stat) irq_clr = icb_cmd_wdata[CH_NUM-1:0];
      else           irq_en_d = icb_cmd_wdata[CH_NUM-1:0];
    end
    irq_stat_d = (irq_stat_q & ~irq_clr) | (done_now & ~done_prev_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_stat_q  <= '0;
      irq_en_q    <= '0;
      done_prev_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      irq_stat_q  <= irq_stat_d;
      irq_en_q    <= irq_en_d;
      done_prev_q <= done_now;
      irq_q       <= |(irq_stat_d & irq_en_d);
    end
  end

  assign irq = irq_q;
`else
  assign glob_ok = 1'b0;
`endif

  always_comb begin
    sr_sel  = '0;
    ctr_sel = '0;
    src_sel = '0;
    dst_sel = '0;
    len_sel = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      if (ch_idx == c) begin
        sr_sel  = ch_sr[c*8 +: 8];
        ctr_sel = ctr_q[c];
        src_sel = src_q[c];
        dst_sel = dst_q[c];
        len_sel = len_q[c];
      end
    end
  end

  // Busy only protects writes that would actually change a register.
  always_comb begin
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    wr_chan     = 1'b0;
    if (!chan_ok && !glob_ok) begin
      rsp_err_d = 1'b1;
    end else if (icb_cmd_read) begin
      if (chan_ok) begin
        if (sel_sr)       rsp_rdata_d = {24'b0, sr_sel};
        else if (sel_ctr) rsp_rdata_d = {24'b0, ctr_sel};
        else if (sel_src) rsp_rdata_d = src_sel;
        else if (sel_dst) rsp_rdata_d = dst_sel;
        else if (sel_len) rsp_rdata_d = len_sel;
      end
`ifdef DMA_CFG_IRQ_EN
      else if (glob_stat) rsp_rdata_d = 32'(irq_stat_q);
      else                rsp_rdata_d = 32'(irq_en_q);
`endif
    end else if (chan_ok) begin
      if (sel_sr)                  rsp_err_d = 1'b1;
      else if (sel_cr)             wr_chan   = 1'b1;
      else if (|icb_cmd_wmask) begin
        if (sr_sel[2]) rsp_err_d = 1'b1;
        else           wr_chan   = 1'b1;
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < CH_NUM; c++)
      we_ch[c] = hs & ~icb_cmd_read & wr_chan & (ch_idx == c);
  end

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] nxt,
                                              input logic [3:0]  m);
    merge_bytes = cur;
    for (int b = 0; b < 4; b++)
      if (m[b]) merge_bytes[b*8 +: 8] = nxt[b*8 +: 8];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < CH_NUM; c++) begin
        ctr_q[c]   <= '0;
        pulse_q[c] <= '0;
        src_q[c]   <= '0;
        dst_q[c]   <= '0;
        len_q[c]   <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < CH_NUM; c++) begin
        pulse_q[c] <= '0;
        if (we_ch[c]) begin
          if (sel_ctr && icb_cmd_wmask[0]) ctr_q[c]   <= icb_cmd_wdata[7:0];
          if (sel_cr && icb_cmd_wmask[0])  pulse_q[c] <= icb_cmd_wdata[7:0];
          if (sel_src) src_q[c] <= merge_bytes(src_q[c], icb_cmd_wdata, icb_cmd_wmask);
          if (sel_dst) dst_q[c] <= merge_bytes(dst_q[c], icb_cmd_wdata, icb_cmd_wmask);
          if (sel_len) len_q[c] <= merge_bytes(len_q[c], icb_cmd_wdata, icb_cmd_wmask);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else if (hs) begin
      rsp_valid_q <= 1'b1;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end else if (rsp_valid_q && icb_rsp_ready) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end
  end

  assign icb_cmd_ready = ~rsp_valid_q;
  assign icb_rsp_valid = rsp_valid_q;
  assign icb_rsp_rdata = rsp_rdata_q;
  assign icb_rsp_err   = rsp_err_q;

  for (genvar g = 0; g < CH_NUM; g++) begin : g_pack
    assign ch_ctr[g*8 +: 8]       = ctr_q[g];
    assign ch_cr_pulse[g*8 +: 8]  = pulse_q[g];
    assign ch_src[g*32 +: 32]     = src_q[g];
    assign ch_dst[g*32 +: 32]     = dst_q[g];
    assign ch_len[g*32 +: 32]     = len_q[g];
  end

endmodule
